fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the 5-stage MIPS core; sits directly upstream of control_unit.

---
 rtl/fetch_stage.sv | 79 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS core.
// Holds the fetch PC, drives the instruction memory address and latches the
// fetched word into D. Supports hazard-unit stall/flush and branch redirect
// resolved in D.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_d,
   input  logic [31:0] pc_branch_d,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_plus4_d,
   output logic [5:0]  opcode_d,
   output logic [5:0]  funct_d,
   output logic        valid_d,
   output logic [31:0] fetch_cnt
);

   logic [31:0] pc_plus4_f;
   logic [31:0] pc_next;
   logic        accept_d;

   // Next-PC selection; branch targets are forced word-aligned
   always_comb begin
      pc_plus4_f = pc_f + 32'd4;
      pc_next    = pc_src_d ? {pc_branch_d[31:2], 2'b00} : pc_plus4_f;
      accept_d   = !stall_d && !flush_d;
   end

   assign imem_addr = pc_f;
   assign opcode_d  = instr_d[31:26];
   assign funct_d   = instr_d[5:0];

   // PC register: a stalled fetch ignores any redirect that cycle
   always_ff @(posedge clk) begin
      if (rst)
         pc_f <= RESET_PC;
      else if (!stall_f)
         pc_f <= pc_next;
   end

   // IF/ID register: stall beats flush so a held instruction is never lost
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_d    <= NOP_INSTR;
         pc_plus4_d <= 32'd0;
         valid_d    <= 1'b0;
      end else if (stall_d) begin
         instr_d    <= instr_d;
         pc_plus4_d <= pc_plus4_d;
         valid_d    <= valid_d;
      end else if (flush_d) begin
         instr_d    <= NOP_INSTR;
         pc_plus4_d <= 32'd0;
         valid_d    <= 1'b0;
      end else begin
         instr_d    <= imem_rdata;
         pc_plus4_d <= pc_plus4_f;
         valid_d    <= 1'b1;
      end
   end

   // Count of real instructions accepted into D (wraps modulo 2^32)
   always_ff @(posedge clk) begin
      if (rst)
         fetch_cnt <= 32'd0;
      else if (accept_d)
         fetch_cnt <= fetch_cnt + 32'd1;
   end

endmodule
